// File: rtl/gray_world_gain_ch_pkg.sv
// Shared constants, sizing helpers and FSM encoding for the gray-world gain stage.
package gray_world_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STAT   = 2'd2
  } state_t;

  // Default fractional precision of the gains and the matching unity value.
  localparam int GAIN_FRAC_DEF = 8;
  localparam int UNITY_GAIN_DEF = 1 << GAIN_FRAC_DEF;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Per-channel frame sum width: large enough for a full frame of max pixels.
  function automatic int sum_w(input int data_w, input int nrows, input int ncol);
    return data_w + clog2(nrows * ncol);
  endfunction

  // Unity gain for a given number of fractional bits.
  function automatic int unity_gain(input int gain_frac);
    return 1 << gain_frac;
  endfunction

endpackage

// File: rtl/gray_world_gain_ch_gain_mul_sat.sv
// One colour channel: register pixel*gain, then round to nearest and saturate.
module gain_mul_sat #(
  parameter int DATA_W    = 8,
  parameter int GAIN_W    = 10,
  parameter int GAIN_FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DATA_W-1:0] pix,
  input  logic [GAIN_W-1:0] gain,
  output logic [DATA_W-1:0] pix_out
);

  localparam int PROD_W = DATA_W + GAIN_W;
  // Half an LSB of the output, added before the truncating shift.
  localparam logic [PROD_W:0] HALF    = {{PROD_W{1'b0}}, 1'b1} << (GAIN_FRAC - 1);
  localparam logic [PROD_W:0] PIX_MAX = {{(PROD_W + 1 - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic [PROD_W-1:0] prod;
  logic [PROD_W:0]   rounded;

  // One extra bit so the rounding addend can never wrap the product.
  assign rounded = ({1'b0, prod} + HALF) >> GAIN_FRAC;

  // Stage 1 holds the raw product, stage 2 the rounded and clipped pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod    <= '0;
      pix_out <= '0;
    end else if (ce) begin
      prod    <= PROD_W'(pix) * PROD_W'(gain);
      pix_out <= (rounded > PIX_MAX) ? {DATA_W{1'b1}} : rounded[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/gray_world_gain_ch.sv
// Per-channel white-balance gain stage with per-frame input statistics.
//
// Handshake: a beat transfers on any edge where tvalid & tready are both high.
// The whole pipeline advances together on ce = !m_axis_tvalid | m_axis_tready,
// and s_axis_tready is exactly ce, so a stalled output freezes every stage and
// holds m_axis_tdata/tuser/tlast stable. Empty slots travel as tvalid = 0.
module gray_world_gain_ch
  import gray_world_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NCH       = 3,
  parameter int GAIN_W    = 10,
  parameter int GAIN_FRAC = 8,
  parameter int Nrows     = 480,
  parameter int Ncol      = 640,
  localparam int SUM_W    = sum_w(DATA_W, Nrows, Ncol)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic [NCH*DATA_W-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [NCH*DATA_W-1:0] m_axis_tdata,
  input  logic [NCH*GAIN_W-1:0] gain_in,
  input  logic                  gain_valid,
  input  logic                  bypass,
  output logic [NCH*SUM_W-1:0]  sum_out,
  output logic                  stat_valid,
  output logic                  frame_err,
  output state_t                dbg_state
);

  localparam int COL_W = cnt_w(Ncol);
  localparam int ROW_W = cnt_w(Nrows);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(Ncol - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(Nrows - 1);
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(GAIN_FRAC));

  logic ce, accept, sof_acc;
  assign ce            = !m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = ce;
  assign accept        = s_axis_tvalid & ce;
  assign sof_acc       = accept & s_axis_tuser;

  // ---------------- gains and bypass ----------------
  logic [NCH*GAIN_W-1:0] gain_pend, gain_act, gain_eff;
  logic                  byp_act, byp_eff;

  // Pending gains load anytime; active gains and bypass only move at an accepted SOF.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_pend <= {NCH{UNITY}};
      gain_act  <= {NCH{UNITY}};
      byp_act   <= 1'b0;
    end else begin
      if (gain_valid) gain_pend <= gain_in;
      if (sof_acc) begin
        gain_act <= gain_pend;
        byp_act  <= bypass;
      end
    end
  end

  // The SOF beat already belongs to the new frame, so it sees the values being latched.
  assign gain_eff = sof_acc ? gain_pend : gain_act;
  assign byp_eff  = sof_acc ? bypass    : byp_act;

  // Bypass is unity gain: (p << FRAC) + half, shifted back, is exactly p.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [GAIN_W-1:0] g;
    assign g = byp_eff ? UNITY : gain_eff[i*GAIN_W +: GAIN_W];
    gain_mul_sat #(
      .DATA_W   (DATA_W),
      .GAIN_W   (GAIN_W),
      .GAIN_FRAC(GAIN_FRAC)
    ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .pix    (s_axis_tdata[i*DATA_W +: DATA_W]),
      .gain   (g),
      .pix_out(m_axis_tdata[i*DATA_W +: DATA_W])
    );
  end

  // ---------------- sideband pipeline ----------------
  logic v1, u1, l1;

  // Valid/SOF/EOL follow the data through the same two enabled stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1            <= 1'b0;
      u1            <= 1'b0;
      l1            <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (ce) begin
      v1            <= accept;
      u1            <= accept & s_axis_tuser;
      l1            <= accept & s_axis_tlast;
      m_axis_tvalid <= v1;
      m_axis_tuser  <= u1;
      m_axis_tlast  <= l1;
    end
  end

  // ---------------- framing FSM and statistics ----------------
  state_t                       state, state_n;
  logic [ROW_W-1:0]             row, row_n, cur_row;
  logic [COL_W-1:0]             col, col_n, cur_col;
  logic [NCH-1:0][SUM_W-1:0]    acc, acc_n, base;
  logic [NCH*SUM_W-1:0]         sum_n;
  logic                         err_n, stat_n;

  // Next state: STAT flushes the sums; any SOF restarts position and sums at this beat.
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    acc_n   = acc;
    sum_n   = sum_out;
    err_n   = 1'b0;
    stat_n  = 1'b0;
    cur_row = row;
    cur_col = col;
    base    = acc;
    if (state == STAT) begin
      stat_n  = 1'b1;
      sum_n   = acc;
      acc_n   = '0;
      base    = '0;
      state_n = IDLE;
    end
    if (accept) begin
      if (s_axis_tuser) begin
        if (state == ACTIVE) err_n = 1'b1;
        state_n = ACTIVE;
        cur_row = '0;
        cur_col = '0;
        base    = '0;
      end
      if (s_axis_tuser || state == ACTIVE) begin
        for (int c = 0; c < NCH; c++)
          acc_n[c] = base[c] + SUM_W'(s_axis_tdata[c*DATA_W +: DATA_W]);
        if (s_axis_tlast) begin
          if (cur_col != COL_LAST) err_n = 1'b1;
          col_n = '0;
          if (cur_row == ROW_LAST) begin
            row_n   = '0;
            state_n = STAT;
          end else begin
            row_n = cur_row + 1'b1;
          end
        end else begin
          col_n = cur_col + 1'b1;
          row_n = cur_row;
        end
      end
    end
  end

  // FSM, position counters, accumulators and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      acc        <= '0;
      sum_out    <= '0;
      stat_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      col        <= col_n;
      acc        <= acc_n;
      sum_out    <= sum_n;
      stat_valid <= stat_n;
      frame_err  <= err_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_gray_world_gain_ch.sv
// Directed bench for gray_world_gain_ch on a 4x4, 3x8-bit configuration.
module tb_gray_world_gain_ch;
  import gray_world_pkg::*;

  localparam int NROWS = 4;
  localparam int NCOL  = 4;
  localparam int PW    = 24;
  localparam int GW    = 30;
  localparam int SUMW  = 8 + $clog2(NROWS * NCOL);
  localparam int SW    = 3 * SUMW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0;
  logic [PW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid, m_user, m_last;
  logic          m_ready = 1'b1;
  logic [PW-1:0] m_data;
  logic [GW-1:0] gain_in = '0;
  logic          gain_valid = 1'b0, bypass = 1'b0;
  logic [SW-1:0] sum_out;
  logic          stat_valid, frame_err;
  state_t        dbg_state;

  gray_world_gain_ch #(
    .DATA_W(8), .NCH(3), .GAIN_W(10), .GAIN_FRAC(8), .Nrows(NROWS), .Ncol(NCOL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tuser(s_user),
    .s_axis_tlast(s_last), .s_axis_tdata(s_data),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tuser(m_user),
    .m_axis_tlast(m_last), .m_axis_tdata(m_data),
    .gain_in(gain_in), .gain_valid(gain_valid), .bypass(bypass),
    .sum_out(sum_out), .stat_valid(stat_valid), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low

  logic [25:0]   exp_q[$];
  logic [SW-1:0] stat_q[$];

  function automatic logic [PW-1:0] px(input int r, input int g, input int b);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic [GW-1:0] gn(input int r, input int g, input int b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  function automatic logic [SW-1:0] sums(input logic [PW-1:0] p, input int n);
    return {SUMW'(n * int'(p[23:16])), SUMW'(n * int'(p[15:8])), SUMW'(n * int'(p[7:0]))};
  endfunction

  // Downstream ready pattern, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'b1 & $urandom_range(0, 1);
      default: m_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  logic        stalled = 1'b0;
  logic        stat_prev = 1'b0;
  logic [25:0] held = '0;
  logic [25:0] exp_e;

  always @(negedge clk) begin
    if (rst) begin
      stalled   = 1'b0;
      stat_prev = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (!m_valid || {m_user, m_last, m_data} !== held) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h, required v=1 %h", m_valid, {m_user, m_last, m_data}, held);
        end
      end
      checks++;
      if (s_ready !== (!m_valid || m_ready)) begin
        errors++;
        $display("FAIL tready_mirror: got %b, required %b", s_ready, (!m_valid || m_ready));
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_extra: got %h, required no beat", {m_user, m_last, m_data});
        end else begin
          exp_e = exp_q.pop_front();
          if ({m_user, m_last, m_data} !== exp_e) begin
            errors++;
            $display("FAIL out_beat: got user=%b last=%b data=%h, required user=%b last=%b data=%h",
                     m_user, m_last, m_data, exp_e[25], exp_e[24], exp_e[23:0]);
          end
        end
      end
      stalled = m_valid && !m_ready;
      held    = {m_user, m_last, m_data};
      if (frame_err) err_cnt++;
      if (stat_valid) begin
        checks++;
        if (stat_prev) begin
          errors++;
          $display("FAIL stat_pulse: stat_valid high on consecutive cycles, required one-cycle pulse");
        end
        stat_q.push_back(sum_out);
      end
      stat_prev = stat_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [PW-1:0] d, input logic sof, input logic eol,
                           input logic gv, input logic [GW-1:0] g);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_user = sof; s_last = eol;
    gain_valid = gv;
    if (gv) gain_in = g;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: beat %h not accepted in 200 cycles", d);
        acc = 1'b1;
      end
    end
    s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0; gain_valid = 1'b0;
  endtask

  task automatic send_px(input logic [PW-1:0] d, input logic sof, input logic eol,
                         input logic [PW-1:0] e, input logic gv, input logic [GW-1:0] g);
    exp_q.push_back({sof, eol, e});
    send_beat(d, sof, eol, gv, g);
  endtask

  task automatic send_frame(input logic [PW-1:0] p, input logic [PW-1:0] e,
                            input logic gv, input logic [GW-1:0] g, input logic gaps);
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOL; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_px(p, (r == 0 && c == 0), (c == NCOL - 1), e, (gv && r == 0 && c == 0), g);
      end
  endtask

  task automatic load_gains(input logic [GW-1:0] g);
    gain_in = g;
    gain_valid = 1'b1;
    @(posedge clk); #1;
    gain_valid = 1'b0;
  endtask

  task automatic check_stat(input logic [SW-1:0] e, input string name);
    int n;
    logic [SW-1:0] got;
    n = 0;
    while (stat_q.size() == 0 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (stat_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no stat_valid pulse within 40 cycles, required sums %h", name, e);
    end else begin
      got = stat_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got sum_out %h, required %h", name, got, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_int(input int got, input int e, input string name);
    checks++;
    if (got != e) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, e);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({m_valid, m_user, m_last, m_data, sum_out, stat_valid, frame_err} !== '0 ||
        dbg_state !== IDLE || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got v=%b u=%b l=%b d=%h sum=%h sv=%b fe=%b st=%0d rdy=%b, required all 0, IDLE, rdy=1",
               name, m_valid, m_user, m_last, m_data, sum_out, stat_valid, frame_err, dbg_state, s_ready);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [GW-1:0] gains;
    logic          byp;
    logic [PW-1:0] pix;
    logic [PW-1:0] exp_px;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{gn(255, 178, 91),  1'b0, px(200, 200, 200), px(199, 139, 71)};
    vecs[1] = '{gn(512, 256, 384), 1'b0, px(200, 37, 101),  px(255, 37, 152)};
    vecs[2] = '{gn(512, 256, 384), 1'b1, px(200, 37, 101),  px(200, 37, 101)};
    vecs[3] = '{gn(1023, 257, 0),  1'b0, px(255, 128, 77),  px(255, 129, 0)};
    vecs[4] = '{gn(256, 256, 256), 1'b0, px(10, 20, 30),    px(10, 20, 30)};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk); #1;

    // Latency: first output two enabled cycles after the accept.
    load_gains(gn(255, 178, 91));
    exp_q.push_back({1'b1, 1'b0, px(199, 139, 71)});
    send_beat(px(200, 200, 200), 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    check_int(int'(m_valid), 0, "latency_1cyc");
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== px(199, 139, 71)) begin
      errors++;
      $display("FAIL latency_2cyc: got v=%b d=%h, required v=1 d=%h", m_valid, m_data, px(199, 139, 71));
    end
    @(posedge clk); #1;
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOL; c++)
        if (r != 0 || c != 0)
          send_px(px(200, 200, 200), 1'b0, (c == NCOL - 1), px(199, 139, 71), 1'b0, '0);
    check_stat(sums(px(200, 200, 200), 16), "stat_latency_frame");

    // Table: gains, saturation, bypass, rounding, stats under random stalls and gaps.
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      load_gains(vecs[i].gains);
      bypass = vecs[i].byp;
      send_frame(vecs[i].pix, vecs[i].exp_px, 1'b0, '0, 1'b1);
      bypass = 1'b0;
      check_stat(sums(vecs[i].pix, 16), $sformatf("stat_vec%0d", i));
    end
    check_int(err_cnt, 0, "no_err_clean_frames");

    // Short first line: EOL at column 1 flags an error, frame still closes after 4 lines.
    rdy_mode = 0;
    load_gains(gn(256, 256, 256));
    send_px(px(1, 2, 3), 1'b1, 1'b0, px(1, 2, 3), 1'b0, '0);
    send_px(px(1, 2, 3), 1'b0, 1'b1, px(1, 2, 3), 1'b0, '0);
    for (int r = 1; r < NROWS; r++)
      for (int c = 0; c < NCOL; c++)
        send_px(px(1, 2, 3), 1'b0, (c == NCOL - 1), px(1, 2, 3), 1'b0, '0);
    check_stat(sums(px(1, 2, 3), 14), "stat_short_line");
    check_int(err_cnt, 1, "err_short_line");

    // SOF injected at row 1 column 2: error, sums restart with the new frame.
    for (int c = 0; c < NCOL; c++)
      send_px(px(100, 100, 100), (c == 0), (c == NCOL - 1), px(100, 100, 100), 1'b0, '0);
    send_px(px(100, 100, 100), 1'b0, 1'b0, px(100, 100, 100), 1'b0, '0);
    send_px(px(100, 100, 100), 1'b0, 1'b0, px(100, 100, 100), 1'b0, '0);
    send_frame(px(5, 6, 7), px(5, 6, 7), 1'b0, '0, 1'b0);
    check_stat(sums(px(5, 6, 7), 16), "stat_after_sof_inject");
    check_int(err_cnt, 2, "err_sof_inject");

    // Reset mid-frame while the output is stalled; pending gains also revert.
    load_gains(gn(512, 512, 512));
    rdy_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    send_px(px(9, 9, 9), 1'b1, 1'b0, px(18, 18, 18), 1'b0, '0);
    send_px(px(9, 9, 9), 1'b0, 1'b0, px(18, 18, 18), 1'b0, '0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_before_reset: got v=%b rdy=%b, required v=1 rdy=0", m_valid, s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    rdy_mode = 0;
    @(negedge clk);
    check_idle_outputs("reset_mid_frame");
    @(posedge clk); #1;

    // Gain update on the SOF cycle of frame 2 takes effect from frame 3; frames back-to-back.
    send_frame(px(50, 60, 70), px(50, 60, 70), 1'b0, '0, 1'b0);
    send_frame(px(50, 60, 70), px(50, 60, 70), 1'b1, gn(512, 128, 256), 1'b0);
    send_frame(px(50, 60, 70), px(100, 30, 70), 1'b0, '0, 1'b0);
    check_stat(sums(px(50, 60, 70), 16), "stat_gain_f1");
    check_stat(sums(px(50, 60, 70), 16), "stat_gain_f2");
    check_stat(sums(px(50, 60, 70), 16), "stat_gain_f3");

    // Drain and final bookkeeping.
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check_int(exp_q.size(), 0, "all_beats_out");
    check_int(stat_q.size(), 0, "no_extra_stat");
    check_int(err_cnt, 2, "err_total");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_world_gain_ch.md
Name: gray_world_gain_ch

Overview:
- Parametrised successor of the fixed 3x8-bit gray_world gain stage.
- Sits on the AXI4-Stream video path after frame_generator or the camera front end.
- Applies per-channel fixed-point white-balance gains, with rounding and saturation, to an NCH-channel pixel stream.
- Accumulates per-channel input sums over each frame for gain estimation, and adds tready backpressure, frame-synchronous gain update, bypass and frame-error detection.

Parameters:
- DATA_W, 8, bits per colour channel.
- NCH, 3, number of channels; channel 0 is in the LSBs, so RGB is R at the MSBs.
- GAIN_W, 10, gain width, unsigned.
- GAIN_FRAC, 8, fractional bits of gain; unity = 1<<GAIN_FRAC.
- Nrows, 480, lines per frame.
- Ncol, 640, pixels per line.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  1  start of frame (SOF).
- s_axis_tlast  in  1  end of line (EOL).
- s_axis_tdata  in  NCH*DATA_W  input pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  SOF, delayed.
- m_axis_tlast  out  1  EOL, delayed.
- m_axis_tdata  out  NCH*DATA_W  gained pixel.
- gain_in  in  NCH*GAIN_W  new gains.
- gain_valid  in  1  load gain_in into the pending register.
- bypass  in  1  pass data unmodified; sampled at SOF.
- sum_out  out  NCH*SUM_W  per-channel input sums of the last complete frame.
- stat_valid  out  1  one-cycle pulse when sum_out updates.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst=1 at clk edge):
  - m_axis_tvalid/tuser/tlast/tdata, sum_out, stat_valid, frame_err all 0.
  - Pending and active gains = unity; bypass_active = 0.
  - FSM in IDLE; row and column counters 0; pipeline contents discarded.
  - Reset is honoured mid-frame, mid-stall and mid-stat without exception.
- Handshake:
  - Accept = s_axis_tvalid & s_axis_tready.
  - Global pipeline enable ce = !m_axis_tvalid | m_axis_tready; s_axis_tready = ce.
  - Output data, tuser and tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
  - Bubbles propagate as valid=0.
- Latency: 2 enabled cycles from accept to m_axis_tvalid.
  - Stage 1 registers the products pixel*gain.
  - Stage 2 rounds: (p + (1<<(GAIN_FRAC-1))) >> GAIN_FRAC, then saturates to 2^DATA_W-1.
  - Product width is DATA_W+GAIN_W.
- Bypass: when bypass_active=1, tdata passes through with the same 2-cycle latency.
- Gains:
  - gain_valid loads gain_in into pending at any cycle.
  - Pending is copied to active on an accepted SOF beat; bypass is sampled at the same beat.
  - If gain_valid coincides with an accepted SOF, the SOF beat uses the old pending value and the new value applies from the next frame.
  - Gains never change mid-frame.
- FSM:
  - IDLE: discard beats (still accepted and passed with gain applied) until an accepted SOF, then go to ACTIVE.
  - ACTIVE: count columns; an accepted EOL increments the row counter.
    - EOL on row Nrows-1 goes to STAT.
    - SOF while ACTIVE and not the first beat: pulse frame_err, clear sums and counters, treat the beat as a new frame start.
    - EOL when column != Ncol-1: pulse frame_err and continue with col=0.
  - STAT: one cycle; latch accumulators into sum_out, pulse stat_valid, clear accumulators, go to IDLE.
  - A SOF arriving during STAT is accepted and handled as IDLE->ACTIVE in that same cycle; no beat is lost.
- Accumulation:
  - Input pixels (pre-gain) are summed per channel on accept, including the SOF beat.
  - SUM_W = DATA_W + clog2(Nrows*Ncol); no overflow is possible.
- Simultaneous events: SOF and EOL on one beat (single-column frame) is legal; both are processed.

Decomposition:
- Package gray_world_pkg holds:
  - the SUM_W computation;
  - the clog2 function;
  - the unity-gain constant;
  - the FSM state encoding (IDLE/ACTIVE/STAT).
- Sub-module gain_mul_sat holds one channel's multiply, round and saturate pipeline (2 registers with ce); it is instantiated NCH times via generate.

Test Plan:
- Gains 255/178/91 loaded before the frame, pixel (200,200,200) -> output (199,139,71), 2 cycles after accept.
- Gain 512 (2.0) on R, pixel R=200 -> R=255 (saturated); G with unity gain and G=37 -> 37.
- Nrows=Ncol=4, constant pixel (10,20,30) -> stat_valid one pulse after the last EOL; sum_out = (160,320,480).
- m_axis_tready toggled 1/0 randomly over a 4x4 frame -> s_axis_tready mirrors the stall, no beats lost or duplicated, output order and tuser/tlast positions intact.
- gain_valid with new gains asserted on the SOF cycle of frame 2 -> frame 2 uses old gains, frame 3 uses new; bypass=1 at SOF -> output equals input.
- SOF injected at column 2 of row 1 -> frame_err pulse, sums restart, next stat_valid reports only the new frame; rst mid-frame -> all outputs 0 the next cycle.
